// File: rtl/ifu_prefetch_pkg.sv
// Shared defaults and sizing helpers for the instruction-fetch prefetch front end.
package ifu_prefetch_pkg;

  localparam int unsigned FETCH_ADDR_W    = 32;
  localparam int unsigned FETCH_INST_W    = 32;
  localparam int unsigned FETCH_DEPTH     = 4;
  localparam int unsigned FETCH_MAX_OUTST = 2;
  localparam logic [31:0] FETCH_RESET_PC  = 32'h8000_0000;
  localparam int unsigned PC_STEP         = 4;

  // Counter width able to hold the value n itself (0..n).
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Bundle of redirect, icache request/response and IF_ID instruction signals around the prefetcher.
interface ifu_prefetch_if
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned INST_W = FETCH_INST_W
);

  logic              redirect_valid_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              icache_req_valid_o;
  logic              icache_req_ready_i;
  logic [ADDR_W-1:0] icache_addr_o;
  logic              icache_data_valid_i;
  logic [INST_W-1:0] icache_data_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i, icache_req_ready_i,
           icache_data_valid_i, icache_data_i, inst_ready_i,
    output icache_req_valid_o, icache_addr_o, inst_valid_o, inst_o, pc_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i, icache_req_ready_i,
           icache_data_valid_i, icache_data_i, inst_ready_i,
    input  icache_req_valid_o, icache_addr_o, inst_valid_o, inst_o, pc_o
  );

endinterface

// File: rtl/ifu_prefetch_fetch_fifo.sv
// Synchronous instruction FIFO holding {inst, pc}; head is read straight from the storage registers.
module ifu_prefetch_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    (push_i && !flush_i && cnt_q == (AW+1)'(DEPTH)) |-> pop_i);

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch PC owner with credit-based pipelined icache prefetch, in-order PC pairing and
// redirect flush that discards responses to requests issued before the redirect.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = FETCH_ADDR_W,
  parameter int unsigned       INST_W    = FETCH_INST_W,
  parameter int unsigned       DEPTH     = FETCH_DEPTH,
  parameter int unsigned       MAX_OUTST = FETCH_MAX_OUTST,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(FETCH_RESET_PC)
) (
  input logic            clk,
  input logic            rst,
  ifu_prefetch_if.master bus
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned OW = cnt_w(MAX_OUTST);
  localparam int unsigned QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned FW = INST_W + ADDR_W;
  localparam logic [OW-1:0] MAX_OUTST_C = OW'(MAX_OUTST);
  localparam logic [CW:0]   DEPTH_C     = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [OW-1:0]     drop_q, drop_d;
  logic [ADDR_W-1:0] pcq_q [MAX_OUTST];
  logic [QW-1:0]     pq_wr_q, pq_wr_d;
  logic [QW-1:0]     pq_rd_q, pq_rd_d;

  logic          redirect, resp, issue_ok, req_fire;
  logic          fifo_push, fifo_pop, fifo_valid;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ;
  logic [FW-1:0] fifo_head;

  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTST - 1)) ? '0 : p + QW'(1);
  endfunction

  assign redirect = bus.redirect_valid_i;
  assign resp     = bus.icache_data_valid_i;

  // Every in-flight request already owns a FIFO slot, so a response can never find the FIFO full.
  assign occ      = {1'b0, fifo_count} + (CW+1)'(outst_q);
  assign issue_ok = rst && !redirect && (outst_q < MAX_OUTST_C) && (occ < DEPTH_C) && (drop_q == '0);
  assign req_fire = issue_ok && bus.icache_req_ready_i;

  assign fifo_push = resp && (drop_q == '0) && !redirect;
  assign fifo_pop  = fifo_valid && bus.inst_ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    pq_wr_d    = pq_wr_q;
    pq_rd_d    = pq_rd_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      pq_wr_d    = qinc(pq_wr_q);
    end
    if (fifo_push) pq_rd_d = qinc(pq_rd_q);

    case ({req_fire, resp})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    // Everything still outstanding after this cycle's response belongs to the old stream.
    if (redirect) begin
      fetch_pc_d = bus.redirect_pc_i & ~ADDR_W'(3);
      drop_d     = resp ? outst_q - OW'(1) : outst_q;
      pq_wr_d    = '0;
      pq_rd_d    = '0;
    end else if (resp && drop_q != '0) begin
      drop_d = drop_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) pcq_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      if (req_fire) pcq_q[pq_wr_q] <= fetch_pc_q;
    end
  end

  ifu_prefetch_fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .wdata_i ({bus.icache_data_i, pcq_q[pq_rd_q]}),
    .head_o  (fifo_head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign bus.icache_req_valid_o = issue_ok;
  assign bus.icache_addr_o      = fetch_pc_q;
  assign bus.inst_valid_o       = fifo_valid;
  assign bus.inst_o             = fifo_head[ADDR_W +: INST_W];
  assign bus.pc_o               = fifo_head[ADDR_W-1:0];

  a_resp_has_req : assert property (@(posedge clk) disable iff (!rst)
    resp |-> (outst_q != '0));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomised self-checking bench for ifu_prefetch: the bench plays the icache from a reference
// memory and checks the consumed instruction stream against the expected PC sequence.
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  localparam int unsigned DEPTH  = FETCH_DEPTH;
  localparam int unsigned MAXO   = FETCH_MAX_OUTST;
  localparam logic [31:0] RST_PC = FETCH_RESET_PC;

  logic clk = 1'b0;
  logic rst;

  ifu_prefetch_if bus ();

  ifu_prefetch #(
    .ADDR_W    (32),
    .INST_W    (32),
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAXO),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] icq [$];     // addresses accepted by the icache, awaiting response
  int          stale;       // responses the icache still owes for pre-redirect requests
  int          bufn;        // instructions the prefetcher should currently be holding
  int          cyc, n_acc, n_cons, n_resp;
  logic [31:0] issue_pc, exp_pc;
  logic        hold_pending;
  logic [31:0] held_addr;
  int          first_acc_cyc, first_val_cyc;
  logic        want_pc, want_acc;
  logic [31:0] first_pc, first_acc_addr;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick(input logic rdy, input logic resp, input logic irdy,
                      input logic redir, input logic [31:0] rpc);
    logic dv, acc, cons, exp_rv;
    dv = resp && (icq.size() > 0);
    bus.icache_req_ready_i  = rdy;
    bus.icache_data_valid_i = dv;
    bus.icache_data_i       = dv ? imem(icq[0]) : $urandom;
    bus.inst_ready_i        = irdy;
    bus.redirect_valid_i    = redir;
    bus.redirect_pc_i       = rpc;
    #1;
    exp_rv = !redir && stale == 0 && int'(icq.size()) < int'(MAXO)
             && int'(icq.size()) + bufn < int'(DEPTH);
    check_eq("req_valid", 32'(bus.icache_req_valid_o), 32'(exp_rv));
    check_eq("inst_valid", 32'(bus.inst_valid_o), 32'(bufn > 0));
    if (hold_pending && !redir) check_eq("addr_hold", bus.icache_addr_o, held_addr);

    acc = bus.icache_req_valid_o && rdy;
    if (acc) begin
      check_eq("req_addr", bus.icache_addr_o, issue_pc);
      icq.push_back(bus.icache_addr_o);
      issue_pc += 32'd4;
      n_acc++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      if (want_acc) begin first_acc_addr = bus.icache_addr_o; want_acc = 1'b0; end
    end
    if (bus.inst_valid_o && first_val_cyc < 0) first_val_cyc = cyc;

    cons = (bufn > 0) && irdy;
    if (cons) begin
      check_eq("pc", bus.pc_o, exp_pc);
      check_eq("inst", bus.inst_o, imem(exp_pc));
      if (want_pc) begin first_pc = bus.pc_o; want_pc = 1'b0; end
      exp_pc += 32'd4;
      bufn--;
      n_cons++;
    end
    if (dv) begin
      void'(icq.pop_front());
      n_resp++;
      if (stale > 0) stale--;
      else if (!redir) bufn++;
    end
    if (redir) begin
      stale    = icq.size();
      bufn     = 0;
      issue_pc = rpc & ~32'd3;
      exp_pc   = rpc & ~32'd3;
      want_pc  = 1'b1;
    end
    hold_pending = bus.icache_req_valid_o && !rdy;
    held_addr    = bus.icache_addr_o;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.icache_req_ready_i  = 1'b0;
    bus.icache_data_valid_i = 1'b0;
    bus.icache_data_i       = '0;
    bus.inst_ready_i        = 1'b0;
    bus.redirect_valid_i    = 1'b0;
    bus.redirect_pc_i       = '0;
    rst = 1'b0;
    #1;
    check_eq("rst_req_valid", 32'(bus.icache_req_valid_o), 32'd0);
    check_eq("rst_addr", bus.icache_addr_o, RST_PC);
    check_eq("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
    check_eq("rst_inst", bus.inst_o, 32'd0);
    check_eq("rst_pc", bus.pc_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    icq.delete();
    stale = 0; bufn = 0; n_resp = 0;
    issue_pc = RST_PC; exp_pc = RST_PC;
    hold_pending = 1'b0;
    first_acc_cyc = -1; first_val_cyc = -1;
    want_pc = 1'b0; want_acc = 1'b1;
    rst = 1'b1;
  endtask

  initial begin
    int base, target, iters;
    logic hit;
    rst = 1'b0;
    cyc = 0; n_acc = 0; n_cons = 0;
    @(negedge clk);

    // Streaming with single-cycle icache: first inst visible two cycles after first request.
    do_reset();
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check_eq("first_req_addr", first_acc_addr, RST_PC);
    check_eq("req_to_valid", 32'(first_val_cyc - first_acc_cyc), 32'd2);

    // Downstream stall: exactly DEPTH instructions buffered, then drained in order.
    do_reset();
    base = n_acc;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_eq("stall_buffered", 32'(n_acc - base), 32'(DEPTH));
    base = n_cons;
    for (int i = 0; i < int'(DEPTH) + 2; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check_eq("stall_drained", 32'(n_cons - base), 32'(DEPTH));

    // Redirect with two requests in flight and two buffered.
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, n_resp < 2, 1'b0, 1'b0, '0);
    first_pc = '0;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0103);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check_eq("redir_first_pc", first_pc, 32'h8000_0100);

    // Redirect coinciding with a response and a consume.
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!hit && icq.size() == 2 && bus.inst_valid_o) begin
        hit = 1'b1;
        tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_1000);
      end else begin
        tick(1'b1, hit || icq.size() >= 2, hit, 1'b0, '0);
      end
    end
    check_eq("same_cycle_redir_hit", 32'(hit), 32'd1);

    // Random backpressure, response timing and redirects over 1000 instructions.
    target = n_cons + 1000;
    iters  = 0;
    while (n_cons < target && iters < 30000) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 59) == 0, $urandom);
      iters++;
    end
    check_eq("random_progress", 32'(n_cons >= target), 32'd1);

    // Reset with requests in flight and FIFO half full.
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, n_resp < 2, 1'b0, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check_eq("restart_addr", first_acc_addr, RST_PC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
